// File: rtl/ifetch_unit.sv
// RV32 instruction-fetch front end: owns the architectural PC, fetches one word
// per PC over a valid/ready memory interface and hands it to decode.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic [31:0] npc,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] inst_count
);

  localparam logic [2:0] BOOT  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;

  localparam logic [1:0] CAUSE_BUS = 2'd1;
  localparam logic [1:0] CAUSE_MIS = 2'd2;

  logic [2:0] state;

  // All handshake outputs decode straight from state so FAULT silences them.
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == HOLD);
  assign fetch_fault    = (state == FAULT);
  assign pc4            = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      inst        <= '0;
      inst_count  <= '0;
      fault_cause <= 2'd0;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ:  if (imem_req_ready) state <= WAIT;
        // Responses are only meaningful here; stray ones elsewhere are dropped.
        WAIT: if (imem_resp_valid) begin
          if (imem_resp_err) begin
            fault_cause <= CAUSE_BUS;
            state       <= FAULT;
          end else begin
            inst  <= imem_resp_data;
            state <= HOLD;
          end
        end
        HOLD: if (inst_ready) begin
          inst_count <= inst_count + 32'd1;
          pc         <= npc;
          if (npc[1:0] != 2'b00) begin
            fault_cause <= CAUSE_MIS;
            state       <= FAULT;
          end else begin
            state <= REQ;
          end
        end
        FAULT:   state <= FAULT;
        default: state <= BOOT;
      endcase
    end
  end

endmodule
